// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiplies by radix-2 shift-add and divides by restoring division, both on
// operand magnitudes, with the sign applied to the result in the final step.
// Every operation takes exactly 32 iterations, which gives a fixed latency of
// 33 cycles from the accept cycle to the one-cycle DONE pulse.
//
// Handshake: md_start_i is sampled only in IDLE, and the accept cycle is the
// IDLE cycle in which it is high. md_busy_o stays high from the cycle after
// accept through the DONE cycle. md_done_o pulses for one cycle together with
// md_result_o, md_rd_o and md_we_o. Requests seen while busy are dropped,
// because there is no queueing.
module muldiv_unit #(
  parameter int MD_XLEN = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               md_start_i,
  input  logic [2:0]         md_funct3_i,
  input  logic [MD_XLEN-1:0] md_rs1_i,
  input  logic [MD_XLEN-1:0] md_rs2_i,
  input  logic [4:0]         md_rd_i,
  output logic               md_busy_o,
  output logic               md_done_o,
  output logic               md_we_o,
  output logic [4:0]         md_rd_o,
  output logic [MD_XLEN-1:0] md_result_o,
  output logic [1:0]         md_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 we_q, we_d;
  logic [4:0]           rd_out_q, rd_out_d;
  logic [MD_XLEN-1:0]   result_q, result_d;

  // Captured operation context
  logic [4:0]           rd_q, rd_d;
  logic                 is_div_q, is_div_d;
  logic                 alt_q, alt_d;        // mul: take high word; div: take remainder
  logic                 neg_q, neg_d;        // negate product / quotient
  logic                 neg_rem_q, neg_rem_d;
  logic [4:0]           cnt_q, cnt_d;

  // Datapath: hi holds the product high word or the partial remainder,
  // lo holds the multiplier/product low word or the dividend/quotient.
  logic [MD_XLEN-1:0]   hi_q, hi_d;
  logic [MD_XLEN-1:0]   lo_q, lo_d;
  logic [MD_XLEN-1:0]   addend_q, addend_d;  // multiplicand or divisor magnitude

  // Capture-time decode
  logic                 sign_a, sign_b;
  logic [MD_XLEN-1:0]   a_mag, b_mag;

  // One-iteration step results
  logic [MD_XLEN:0]     mul_sum;
  logic [MD_XLEN:0]     div_shift;
  logic                 div_ge;
  logic [MD_XLEN-1:0]   hi_n, lo_n;

  // Final sign fix-up and result selection
  logic [2*MD_XLEN-1:0] product, prod_fix;
  logic [MD_XLEN-1:0]   quo_fix, rem_fix, final_res;

  assign md_busy_o   = busy_q;
  assign md_done_o   = done_q;
  assign md_we_o     = we_q;
  assign md_rd_o     = rd_out_q;
  assign md_result_o = result_q;
  assign md_state_o  = state_q;

  // Operand signedness and magnitudes for the incoming request
  always_comb begin
    sign_a = md_rs1_i[MD_XLEN-1] & ((md_funct3_i == 3'b001) || (md_funct3_i == 3'b010) ||
                                    (md_funct3_i == 3'b100) || (md_funct3_i == 3'b110));
    sign_b = md_rs2_i[MD_XLEN-1] & ((md_funct3_i == 3'b001) || (md_funct3_i == 3'b100) ||
                                    (md_funct3_i == 3'b110));
    a_mag  = sign_a ? (~md_rs1_i + 1'b1) : md_rs1_i;
    b_mag  = sign_b ? (~md_rs2_i + 1'b1) : md_rs2_i;
  end

  // One shift-add (multiply) or restoring-subtract (divide) iteration
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
    div_shift = {hi_q, lo_q[MD_XLEN-1]};
    div_ge    = (div_shift >= {1'b0, addend_q});
    if (is_div_q) begin
      // When the trial subtraction succeeds the difference is below the
      // divisor, so the low-word subtraction is exact.
      hi_n = div_ge ? (div_shift[MD_XLEN-1:0] - addend_q) : div_shift[MD_XLEN-1:0];
      lo_n = {lo_q[MD_XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[MD_XLEN:1];
      lo_n = {mul_sum[0], lo_q[MD_XLEN-1:1]};
    end
  end

  // Sign fix-up of the last iteration's values and result selection
  always_comb begin
    product   = {hi_n, lo_n};
    prod_fix  = neg_q ? (~product + 1'b1) : product;
    quo_fix   = neg_q ? (~lo_n + 1'b1) : lo_n;
    rem_fix   = neg_rem_q ? (~hi_n + 1'b1) : hi_n;
    if (is_div_q) begin
      final_res = alt_q ? rem_fix : quo_fix;
    end else begin
      final_res = alt_q ? prod_fix[2*MD_XLEN-1:MD_XLEN] : prod_fix[MD_XLEN-1:0];
    end
  end

  // Next-state logic for the IDLE -> CALC -> DONE sequence
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    we_d      = we_q;
    rd_out_d  = rd_out_q;
    result_d  = result_q;
    rd_d      = rd_q;
    is_div_d  = is_div_q;
    alt_d     = alt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    addend_d  = addend_q;
    unique case (state_q)
      S_IDLE: begin
        if (md_start_i) begin
          state_d   = S_CALC;
          busy_d    = 1'b1;
          cnt_d     = '0;
          rd_d      = md_rd_i;
          is_div_d  = md_funct3_i[2];
          alt_d     = md_funct3_i[2] ? md_funct3_i[1] : (md_funct3_i[1:0] != 2'b00);
          // A zero divisor yields an all-ones quotient magnitude, and that
          // value is returned unsigned, so it must not be negated.
          neg_d     = (sign_a ^ sign_b) & (~md_funct3_i[2] | (md_rs2_i != '0));
          neg_rem_d = sign_a;
          hi_d      = '0;
          lo_d      = md_funct3_i[2] ? a_mag : b_mag;
          addend_d  = md_funct3_i[2] ? b_mag : a_mag;
        end
      end
      S_CALC: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          we_d     = (rd_q != 5'd0);
          rd_out_d = rd_q;
          result_d = final_res;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        we_d    = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over a concurrent start
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      rd_out_q  <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      alt_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      addend_q  <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
      rd_out_q  <= rd_out_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      is_div_q  <= is_div_d;
      alt_q     <= alt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      addend_q  <= addend_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed corner cases
// and randomized RV32M operations checked against an arithmetic reference.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        busy, done, we;
  logic [4:0]  rd_o;
  logic [31:0] result;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 0;

  logic [31:0] exp_q[$];
  logic        exp_we_q[$];
  logic [4:0]  exp_rd_q[$];
  int          exp_cyc_q[$];
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  muldiv_unit #(.MD_XLEN(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .md_start_i  (start),
    .md_funct3_i (funct3),
    .md_rs1_i    (rs1),
    .md_rs2_i    (rs2),
    .md_rd_i     (rd),
    .md_busy_o   (busy),
    .md_done_o   (done),
    .md_we_o     (we),
    .md_rd_o     (rd_o),
    .md_result_o (result),
    .md_state_o  (state)
  );

  // Clock and cycle counter: during cycle k, cyc == k
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%08h req=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model from RV32M arithmetic rules
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin
        logic [63:0] up;
        up = {32'd0, a} * {32'd0, b};
        return up[63:32];
      end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: busy window, done timing and write-back contents
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        logic exp_busy;
        exp_busy = (exp_cyc_q.size() > 0) && (cyc >= exp_cyc_q[0] - 32);
        chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
          errors++;
          checks++;
          $display("FAIL missing_done act=none req=done_at_%0d", exp_cyc_q[0]);
          void'(exp_q.pop_front()); void'(exp_we_q.pop_front());
          void'(exp_rd_q.pop_front()); void'(exp_cyc_q.pop_front());
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_done act=1 req=0 (cycle %0d)", cyc);
          end else begin
            chk("done_cycle", cyc, exp_cyc_q.pop_front());
            last_res = exp_q.pop_front();
            last_rd  = exp_rd_q.pop_front();
            chk("result", result, last_res);
            chk("rd_o", {27'd0, rd_o}, {27'd0, last_rd});
            chk("we", {31'd0, we}, {31'd0, exp_we_q.pop_front()});
          end
        end else begin
          chk("we_idle", {31'd0, we}, 32'd0);
          chk("result_hold", result, last_res);
          chk("rd_hold", {27'd0, rd_o}, {27'd0, last_rd});
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
    #1;
  endtask

  // Wait until every outstanding op has completed, then one more cycle so
  // the DUT is back in IDLE
  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      checks++;
      $display("FAIL wait_idle act=busy req=idle");
      exp_q.delete(); exp_we_q.delete(); exp_rd_q.delete(); exp_cyc_q.delete();
    end
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] r, input logic [4:0] d, input int done_cyc);
    exp_q.push_back(r);
    exp_we_q.push_back(d != 5'd0);
    exp_rd_q.push_back(d);
    exp_cyc_q.push_back(done_cyc);
  endtask

  // Driver: issue one op in IDLE, then scramble the inputs
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic [31:0] exp_r, output int t);
    wait_idle();
    start  = 1'b1;
    funct3 = f;
    rs1    = a;
    rs2    = b;
    rd     = d;
    t      = cyc;
    push_exp(exp_r, d, t + 33);
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    rs1    = $urandom;
    rs2    = $urandom;
    rd     = 5'($urandom_range(0, 31));
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t;
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  d;
    rst_n  = 1'b0;
    start  = 1'b1;
    funct3 = 3'b000;
    rs1    = 32'd1;
    rs2    = 32'd1;
    rd     = 5'd1;
    repeat (3) @(negedge clk);
    // Reset state, with start held high to show reset has priority
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_rd", {27'd0, rd_o}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    #1;
    start  = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed corner cases
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, t);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, t);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, t);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, t);
    issue(3'b101, 32'd100, 32'd0, 5'd7, 32'hFFFF_FFFF, t);
    issue(3'b100, 32'hFFFF_FFF9, 32'd0, 5'd8, 32'hFFFF_FFFF, t);
    issue(3'b110, 32'hFFFF_FFF9, 32'd0, 5'd9, 32'hFFFF_FFF9, t);
    issue(3'b111, 32'd55, 32'd0, 5'd10, 32'd55, t);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, t);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, t);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFF, t);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFD, t);
    issue(3'b100, 32'd20, 32'd3, 5'd0, 32'd6, t);

    // Start held high from T+5 is ignored until IDLE at T+34
    issue(3'b000, 32'd9, 32'd11, 5'd15, 32'd99, t);
    wait_cyc(t + 5);
    start  = 1'b1;
    funct3 = 3'b101;
    rs1    = 32'd1000;
    rs2    = 32'd7;
    rd     = 5'd16;
    push_exp(32'd142, 5'd16, t + 34 + 33);
    wait_cyc(t + 35);
    start = 1'b0;

    // Reset in the middle of an operation
    issue(3'b000, 32'd5, 32'd6, 5'd17, 32'd30, t);
    wait_cyc(t + 10);
    rst_n = 1'b0;
    exp_q.delete(); exp_we_q.delete(); exp_rd_q.delete(); exp_cyc_q.delete();
    last_res = '0;
    last_rd  = '0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_we", {31'd0, we}, 32'd0);
    chk("abort_result", result, 32'd0);
    #1;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    issue(3'b000, 32'd3, 32'd4, 5'd18, 32'h0000_000C, t);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = rand_operand();
      b = rand_operand();
      d = 5'($urandom_range(0, 31));
      issue(f, a, b, d, ref_model(f, a, b), t);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
